// File: rtl/pick_ctrl.sv
// pick_ctrl: tile-selection controller.
// Turns cursor + select strobes into a pair of picked cells (A, B), issues a match
// request to the path checker, and pulses a clear mask on a successful match.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-low reset
//   cur_bus    one-hot cursor position
//   sel        select strobe, one cycle per press
//   cell_valid 1 = tile present in that cell
//   chk_ack    checker response strobe
//   chk_ok     checker verdict, valid with chk_ack
//   chk_req    match request, held until ack (or timeout)
//   chk_a      index of first pick
//   chk_b      index of second pick
//   sel_bus    highlight mask of picked cells
//   clr_bus    one-cycle pulse, cells to remove
//   busy       high while a request is outstanding
//
// Optional feature: define PICK_TIMEOUT_EN to abort a request that sees no
// chk_ack within TO_CYCLES cycles (treated as a failed match).
module pick_ctrl #(
  parameter int unsigned CELLS     = 36,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned TO_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CELLS-1:0] cur_bus,
  input  logic             sel,
  input  logic [CELLS-1:0] cell_valid,
  input  logic             chk_ack,
  input  logic             chk_ok,
  output logic             chk_req,
  output logic [IDX_W-1:0] chk_a,
  output logic [IDX_W-1:0] chk_b,
  output logic [CELLS-1:0] sel_bus,
  output logic [CELLS-1:0] clr_bus,
  output logic             busy
);

  localparam logic [CELLS-1:0] CellOne = {{(CELLS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StOne,
    StReq
  } state_e;

  state_e           r_state, w_state_d;
  logic [IDX_W-1:0] r_a, w_a_d;
  logic [IDX_W-1:0] r_b, w_b_d;
  logic [CELLS-1:0] r_sel_bus, w_sel_bus_d;
  logic [CELLS-1:0] r_clr_bus, w_clr_bus_d;

  logic             w_onehot;
  logic             w_legal;
  logic [IDX_W-1:0] w_idx;
  logic [CELLS-1:0] w_bit_a;
  logic [CELLS-1:0] w_bit_cur;
  logic             w_timeout;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign w_onehot  = (cur_bus != '0) && ((cur_bus & (cur_bus - CellOne)) == '0);
  assign w_legal   = sel && w_onehot && ((cur_bus & cell_valid) != '0);
  assign w_bit_a   = CellOne << r_a;
  assign w_bit_cur = CellOne << w_idx;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (cur_bus[i]) w_idx = IDX_W'(i);
    end
  end

`ifdef PICK_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TO_CYCLES + 1);

  logic [CntW-1:0] r_cnt, w_cnt_d, w_cnt_inc;

  assign w_cnt_inc = r_cnt + CntW'(1);
  // Fires on the edge that closes the TO_CYCLES-th cycle spent in REQ.
  assign w_timeout = (r_state == StReq) && (w_cnt_inc == CntW'(TO_CYCLES));

  // Held at zero outside REQ so it starts from zero on every REQ entry.
  always_comb begin
    w_cnt_d = '0;
    if (r_state == StReq) w_cnt_d = w_cnt_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= w_cnt_d;
  end
`else
  logic w_unused_to;
  assign w_unused_to = (TO_CYCLES == 0);
  assign w_timeout   = 1'b0;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_a_d       = r_a;
    w_b_d       = r_b;
    w_sel_bus_d = r_sel_bus;
    w_clr_bus_d = '0;
    unique case (r_state)
      StIdle: begin
        if (w_legal) begin
          w_a_d       = w_idx;
          w_sel_bus_d = w_bit_cur;
          w_state_d   = StOne;
        end
      end
      StOne: begin
        // Losing the tile under A wins over any strobe in the same cycle.
        if (!cell_valid[r_a]) begin
          w_sel_bus_d = '0;
          w_state_d   = StIdle;
        end else if (sel && w_onehot && (w_idx == r_a)) begin
          w_sel_bus_d = '0;
          w_state_d   = StIdle;
        end else if (w_legal) begin
          w_b_d       = w_idx;
          w_sel_bus_d = w_bit_a | w_bit_cur;
          w_state_d   = StReq;
        end
      end
      StReq: begin
        // Ack beats a coincident timeout; sel is ignored here.
        if (chk_ack) begin
          if (chk_ok) w_clr_bus_d = r_sel_bus;
          w_sel_bus_d = '0;
          w_state_d   = StIdle;
        end else if (w_timeout) begin
          w_sel_bus_d = '0;
          w_state_d   = StIdle;
        end
      end
      default: begin
        w_sel_bus_d = '0;
        w_state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_a       <= '0;
      r_b       <= '0;
      r_sel_bus <= '0;
      r_clr_bus <= '0;
    end else begin
      r_state   <= w_state_d;
      r_a       <= w_a_d;
      r_b       <= w_b_d;
      r_sel_bus <= w_sel_bus_d;
      r_clr_bus <= w_clr_bus_d;
    end
  end

  assign chk_req = (r_state == StReq);
  assign busy    = (r_state == StReq);
  assign chk_a   = r_a;
  assign chk_b   = r_b;
  assign sel_bus = r_sel_bus;
  assign clr_bus = r_clr_bus;

endmodule

// File: doc/pick_ctrl.md
# pick_ctrl

Tile-selection controller sitting downstream of the cursor block: it consumes the 36-bit one-hot cursor bus plus a select pulse and turns them into a pair of picked cells. It then issues a match request to the path checker and, on a successful match, pulses a clear mask so the board removes both tiles. It also drives the highlight mask used by the display.

## Interface
Parameters:
- CELLS, 36, number of board cells; width of all cell buses (6x6 grid)
- IDX_W, 6, width of a cell index
- TO_CYCLES, 1000, request timeout in clock cycles; used only when PICK_TIMEOUT_EN is defined

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cur_bus  in  CELLS  one-hot cursor position from cursor block
- sel  in  1  select strobe, debounced, one cycle per press
- cell_valid  in  CELLS  1 = tile present in that cell
- chk_ack  in  1  checker response strobe, one cycle
- chk_ok  in  1  checker verdict, valid only with chk_ack
- chk_req  out  1  match request, level, held until ack
- chk_a  out  IDX_W  index of first pick
- chk_b  out  IDX_W  index of second pick
- sel_bus  out  CELLS  highlight mask of picked cells
- clr_bus  out  CELLS  one-cycle pulse, cells to remove
- busy  out  1  high in REQ state

## Operation
- Index encoding: position of the single set bit in cur_bus, bit 0 -> 0, bit 35 -> 35. A strobe is "legal" only if cur_bus has exactly one bit set and that cell's cell_valid bit = 1; illegal strobes are ignored with no state change.
- States: IDLE, ONE, REQ.
- IDLE: a legal sel latches the first index into A, sets sel_bus bit A, and moves to ONE.
- ONE:
  - A sel on the same cell as A deselects: sel_bus cleared, state returns to IDLE.
  - A legal sel on a different cell latches B, sets sel_bus bit B, and moves to REQ.
  - If cell_valid[A] drops while in ONE, the selection is cleared and the state returns to IDLE.
- REQ:
  - chk_req = 1 and busy = 1; chk_a and chk_b are held stable; sel is ignored.
  - On chk_ack with chk_ok = 1: clr_bus = bit A | bit B for exactly one cycle, sel_bus cleared, state returns to IDLE.
  - On chk_ack with chk_ok = 0: sel_bus cleared, no clr_bus pulse, state returns to IDLE.
- chk_ack outside REQ is ignored.
- Reset (async, any state including REQ): state = IDLE. All outputs = 0, including chk_a, chk_b, sel_bus, clr_bus, chk_req and busy.

## Timing
- All outputs are registered.
- Latency: sel sampled at edge k -> sel_bus/state updated after edge k.
- chk_req rises after the edge that samples the second legal sel.
- chk_ack sampled at edge k -> chk_req falls and clr_bus rises after edge k; clr_bus falls after edge k+1.
- Earliest new pick: the sel sampled one edge after the ack edge is honoured in IDLE.
- Simultaneous sel and chk_ack in REQ: ack processed, sel dropped.
- Simultaneous sel on A and drop of cell_valid[A] in ONE: result is IDLE either way.

## Configuration
- PICK_TIMEOUT_EN defined: a cycle counter of width ceil(log2(TO_CYCLES+1)) clears on REQ entry and counts every cycle in REQ.
  - When the count reaches TO_CYCLES without chk_ack, the controller aborts: treated as chk_ok = 0, sel_bus cleared, state to IDLE.
  - chk_ack on the same edge as the timeout wins.
- PICK_TIMEOUT_EN undefined: no counter; REQ waits for chk_ack indefinitely; TO_CYCLES unused.

## Test plan
- Reset low mid-REQ (A=3, B=10) -> all outputs 0 immediately, not waiting for a clock edge; after release, state IDLE.
- cur_bus=bit 0, sel; cur_bus=bit 35, sel; chk_ack with chk_ok=1 after 4 cycles:
  - chk_a=0, chk_b=35, chk_req held 4 cycles.
  - clr_bus=bit0|bit35 for 1 cycle, sel_bus=0.
- Illegal strobes leave state and outputs unchanged:
  - sel with cur_bus=0.
  - sel with cur_bus=bits 2 and 3 set.
  - sel on a cell with cell_valid=0.
- Pick cell 7, sel on cell 7 again -> sel_bus=0, IDLE. Pick cell 7, then drop cell_valid[7] -> sel_bus=0 next cycle.
- A=5, B=6, chk_ack with chk_ok=0 -> no clr_bus pulse, sel_bus=0. sel pulses during REQ ignored; chk_a/chk_b unchanged throughout.
- With PICK_TIMEOUT_EN and TO_CYCLES=8, no ack -> chk_req falls after 8 REQ cycles, clr_bus stays 0. Without the macro, chk_req stays high 100+ cycles.
